// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg
//   Shared types and constants for the instruction encoder/loader:
//   FSM state encoding, op/cond field codes that the loader treats as
//   illegal, sticky error-bit positions and the field-to-word encoder.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int ERR_OP   = 0;
  localparam int ERR_COND = 1;
  localparam int ERR_OVF  = 2;
  localparam int ERR_W    = 3;

  // All formats share one layout; a branch's imm24 is simply the
  // concatenation of funct[3:0], rn, rd and src2.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2
  );
    return {cond, op, funct, rn, rd, src2};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo
//   Synchronous FIFO, DEPTH entries (power of 2) of DATA_W bits.
//   Ports:
//     clk, rst_n     clock, async active-low reset (pointers/count only)
//     push, din      write an entry (ignored when full)
//     pop            discard head entry (ignored when empty)
//     dout           current head entry
//     full, empty    occupancy flags
//     count          current occupancy, 0..DEPTH
module instr_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes ARMv4 instruction field sets into 32-bit words and writes them
//   sequentially into instruction memory starting at a programmable base.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     start, base_addr           open a load session (IDLE only) at base_addr
//     in_valid/in_ready/in_last  field-set stream handshake, last marks end
//     in_cond..in_src2           instruction fields, bits 31:28 .. 11:0
//     mem_we/mem_addr/mem_wdata  imem write request, held while mem_ready=0
//     mem_ready                  imem accepts the write this cycle
//     busy                       session in progress
//     done                       one-cycle pulse when the session ends
//     word_count                 words written this session
//     err                        sticky: [0] op==11, [1] cond==NV, [2] overflow
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter  int ADDR_W    = 12,
  parameter  int DEPTH     = 4,
  parameter  int MAX_WORDS = 256,
  localparam int WC_W      = $clog2(MAX_WORDS) + 1,
  localparam int OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [WC_W-1:0]   word_count,
  output logic [ERR_W-1:0]  err
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       head;
  logic              full;
  logic              empty;
  logic [OCC_W-1:0]  occ;
  logic              xfer;
  logic              bad_op;
  logic              bad_cond;
  logic              at_limit;
  logic              push;
  logic              pop;
  logic [WC_W:0]     total;

  // ---- accept stage: handshake, legality and overflow screening ----
  assign in_ready = (state == RUN) && !full;
  assign xfer     = in_valid && in_ready;
  assign bad_op   = (in_op == OP_ILL);
  assign bad_cond = (in_cond == COND_NV);

  // Words already written plus words still queued; once this reaches
  // MAX_WORDS any further legal word would overrun the session budget.
  assign total    = (WC_W+1)'(word_count) + (WC_W+1)'(occ);
  assign at_limit = (total >= (WC_W+1)'(MAX_WORDS));
  assign push     = xfer && !bad_op && !bad_cond && !at_limit;

  instr_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (encode_word(in_cond, in_op, in_funct, in_rn, in_rd, in_src2)),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // ---- write stage: FIFO head to imem ----
  assign mem_we    = !empty && ((state == RUN) || (state == DRAIN));
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = addr_q;
  // Stale storage is never exposed; the port reads zero whenever idle.
  assign mem_wdata = empty ? 32'h0 : head;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      addr_q     <= '0;
      word_count <= '0;
      err        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            addr_q     <= base_addr & ~ADDR_W'(3);
            word_count <= '0;
            err        <= '0;
          end
        end
        RUN: begin
          if (xfer && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        word_count <= word_count + WC_W'(1);
        addr_q     <= addr_q + ADDR_W'(4);
      end

      if (xfer) begin
        if (bad_op)   err[ERR_OP]   <= 1'b1;
        if (bad_cond) err[ERR_COND] <= 1'b1;
        if (!bad_op && !bad_cond && at_limit) err[ERR_OVF] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_s [2];
  logic [11:0] base_s  [2];
  logic        vld_s   [2];
  logic        last_s  [2];
  logic [3:0]  cond_s  [2];
  logic [1:0]  op_s    [2];
  logic [5:0]  funct_s [2];
  logic [3:0]  rn_s    [2];
  logic [3:0]  rd_s    [2];
  logic [11:0] src2_s  [2];
  logic        mrdy_s  [2];

  logic        rdy_s   [2];
  logic        we_s    [2];
  logic [11:0] maddr_s [2];
  logic [31:0] wdata_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [2:0]  err_s   [2];
  logic [8:0]  wc0;
  logic [2:0]  wc1;

  wr_t q0[$];
  wr_t q1[$];

  int ntests = 0;
  int nfail  = 0;
  int acc_cnt [2];

  logic        stall_prev [2] = '{1'b0, 1'b0};
  logic [11:0] paddr      [2];
  logic [31:0] pdata      [2];

  always #5 clk = ~clk;

  instr_encoder_loader dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .base_addr(base_s[0]),
    .in_valid(vld_s[0]), .in_ready(rdy_s[0]), .in_last(last_s[0]),
    .in_cond(cond_s[0]), .in_op(op_s[0]), .in_funct(funct_s[0]),
    .in_rn(rn_s[0]), .in_rd(rd_s[0]), .in_src2(src2_s[0]),
    .mem_we(we_s[0]), .mem_addr(maddr_s[0]), .mem_wdata(wdata_s[0]),
    .mem_ready(mrdy_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .word_count(wc0), .err(err_s[0])
  );

  instr_encoder_loader #(.MAX_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .base_addr(base_s[1]),
    .in_valid(vld_s[1]), .in_ready(rdy_s[1]), .in_last(last_s[1]),
    .in_cond(cond_s[1]), .in_op(op_s[1]), .in_funct(funct_s[1]),
    .in_rn(rn_s[1]), .in_rd(rd_s[1]), .in_src2(src2_s[1]),
    .mem_we(we_s[1]), .mem_addr(maddr_s[1]), .mem_wdata(wdata_s[1]),
    .mem_ready(mrdy_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .word_count(wc1), .err(err_s[1])
  );

  function automatic logic [8:0] get_wc(input int d);
    return (d == 0) ? wc0 : {6'b0, wc1};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every accepted write and checks
  // that a stalled request holds its address and data.
  task automatic mon(input int d);
    wr_t e;
    logic got;
    if (!rst_n) begin
      stall_prev[d] = 1'b0;
      return;
    end
    if (stall_prev[d]) begin
      ntests++;
      if (!(we_s[d] === 1'b1 && maddr_s[d] === paddr[d] && wdata_s[d] === pdata[d])) begin
        nfail++;
        $display("FAIL stall_stable dut%0d: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                 d, we_s[d], maddr_s[d], wdata_s[d], paddr[d], pdata[d]);
      end
    end
    if (we_s[d] && mrdy_s[d]) begin
      got = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      ntests++;
      if (!got) begin
        nfail++;
        $display("FAIL unexpected_write dut%0d: got addr=%h data=%h, expected no write",
                 d, maddr_s[d], wdata_s[d]);
      end else if (maddr_s[d] !== e.a || wdata_s[d] !== e.d) begin
        nfail++;
        $display("FAIL write dut%0d: got addr=%h data=%h, expected addr=%h data=%h",
                 d, maddr_s[d], wdata_s[d], e.a, e.d);
      end
    end
    stall_prev[d] = we_s[d] && !mrdy_s[d];
    paddr[d] = maddr_s[d];
    pdata[d] = wdata_s[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic do_start(input int d, input logic [11:0] b);
    start_s[d] = 1'b1;
    base_s[d]  = b;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    chk("start_busy", {31'b0, busy_s[d]}, 32'd1);
  endtask

  task automatic send(input int d, input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [3:0] n, input logic [3:0] r,
                      input logic [11:0] s, input logic lst, input logic keep,
                      input logic [11:0] ea, input logic [31:0] ew);
    int t = 0;
    cond_s[d] = c; op_s[d] = o; funct_s[d] = f;
    rn_s[d] = n; rd_s[d] = r; src2_s[d] = s;
    last_s[d] = lst;
    vld_s[d] = 1'b1;
    while (!rdy_s[d] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy_s[d]) begin
      ntests++;
      nfail++;
      $display("FAIL send_timeout dut%0d: got in_ready=0 after %0d cycles, expected 1", d, t);
      vld_s[d] = 1'b0;
      last_s[d] = 1'b0;
      return;
    end
    @(posedge clk);
    if (keep) begin
      if (d == 0) q0.push_back('{a: ea, d: ew});
      else        q1.push_back('{a: ea, d: ew});
    end
    acc_cnt[d]++;
    #1;
    vld_s[d] = 1'b0;
    last_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input logic [8:0] exp_wc, input logic [2:0] exp_err);
    int n = 0;
    @(negedge clk);
    while (!done_s[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'b0, done_s[d]}, 32'd1);
    chk("word_count", {23'b0, get_wc(d)}, {23'b0, exp_wc});
    chk("err", {29'b0, err_s[d]}, {29'b0, exp_err});
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done_s[d]}, 32'd0);
    chk("busy_after_done", {31'b0, busy_s[d]}, 32'd0);
    chk("err_held", {29'b0, err_s[d]}, {29'b0, exp_err});
    chk("scoreboard_drained", qsize(d), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 0; base_s[d] = '0; vld_s[d] = 0; last_s[d] = 0;
      cond_s[d] = '0; op_s[d] = '0; funct_s[d] = '0; rn_s[d] = '0;
      rd_s[d] = '0; src2_s[d] = '0; mrdy_s[d] = 1'b1; acc_cnt[d] = 0;
    end

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, rdy_s[0]}, 32'd0);
    chk("rst_mem_we", {31'b0, we_s[0]}, 32'd0);
    chk("rst_busy", {31'b0, busy_s[0]}, 32'd0);
    chk("rst_done", {31'b0, done_s[0]}, 32'd0);
    chk("rst_word_count", {23'b0, wc0}, 32'd0);
    chk("rst_err", {29'b0, err_s[0]}, 32'd0);
    chk("rst_mem_addr", {20'b0, maddr_s[0]}, 32'd0);
    chk("rst_mem_wdata", wdata_s[0], 32'd0);
    chk("rst_busy_dut1", {31'b0, busy_s[1]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADD R2,R1,#5 at 0x100
    do_start(0, 12'h100);
    send(0, 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 1'b1, 1'b1, 12'h100, 32'hE2812005);
    chk("first_write_latency", {31'b0, we_s[0]}, 32'd1);
    wait_done(0, 9'd1, 3'b000);

    // LDR then branch, base 0
    do_start(0, 12'h000);
    send(0, 4'hE, 2'b01, 6'b011001, 4'h4, 4'h3, 12'h008, 1'b0, 1'b1, 12'h000, 32'hE5943008);
    send(0, 4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h003, 1'b1, 1'b1, 12'h004, 32'hEA000003);
    wait_done(0, 9'd2, 3'b000);

    // memory stall with 6 MOV Rk,#k words; a stray start mid-run is ignored
    do_start(0, 12'h200);
    mrdy_s[0] = 1'b0;
    acc_cnt[0] = 0;
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send(0, 4'hE, 2'b00, 6'b111010, 4'h0, 4'(k), 12'(k), (k == 6), 1'b1,
               12'h200 + 12'(4 * (k - 1)), 32'hE3A00000 + 32'(k) * 32'h1000 + 32'(k));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        base_s[0]  = 12'h7F0;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'b0, rdy_s[0]}, 32'd0);
        chk("stall_accepted", acc_cnt[0], 32'd4);
        chk("stall_we", {31'b0, we_s[0]}, 32'd1);
        chk("stall_addr", {20'b0, maddr_s[0]}, 32'h200);
        chk("stall_data", wdata_s[0], 32'hE3A01001);
        mrdy_s[0] = 1'b1;
      end
    join
    wait_done(0, 9'd6, 3'b000);

    // op==11 in the middle of three
    do_start(0, 12'h010);
    send(0, 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 1'b0, 1'b1, 12'h010, 32'hE2812005);
    send(0, 4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0);
    send(0, 4'hE, 2'b01, 6'b011001, 4'h4, 4'h3, 12'h008, 1'b1, 1'b1, 12'h014, 32'hE5943008);
    wait_done(0, 9'd2, 3'b001);

    // cond==NV as the last word; unaligned base 0x0F3 -> 0x0F0
    do_start(0, 12'h0F3);
    send(0, 4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h003, 1'b0, 1'b1, 12'h0F0, 32'hEA000003);
    send(0, 4'hF, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 1'b1, 1'b0, 12'h000, 32'h0);
    wait_done(0, 9'd1, 3'b010);

    // MAX_WORDS=4 instance: 6 words offered, address wraps past 0xFFC
    do_start(1, 12'hFF8);
    for (int k = 1; k <= 6; k++)
      send(1, 4'hE, 2'b00, 6'b111010, 4'h0, 4'(k), 12'(k), (k == 6), (k <= 4),
           12'hFF8 + 12'(4 * (k - 1)), 32'hE3A00000 + 32'(k) * 32'h1000 + 32'(k));
    wait_done(1, 9'd4, 3'b100);

    // reset during DRAIN with three words queued
    do_start(0, 12'h300);
    mrdy_s[0] = 1'b0;
    for (int k = 1; k <= 3; k++)
      send(0, 4'hE, 2'b00, 6'b111010, 4'h0, 4'(k), 12'(k), (k == 3), 1'b0,
           12'h000, 32'h0);
    chk("drain_busy", {31'b0, busy_s[0]}, 32'd1);
    chk("drain_we", {31'b0, we_s[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", {31'b0, we_s[0]}, 32'd0);
    chk("async_rst_busy", {31'b0, busy_s[0]}, 32'd0);
    chk("async_rst_wc", {23'b0, wc0}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mrdy_s[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_we", {31'b0, we_s[0]}, 32'd0);
    do_start(0, 12'h040);
    send(0, 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 1'b1, 1'b1, 12'h040, 32'hE2812005);
    wait_done(0, 9'd1, 3'b000);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
